// File: rtl/dm_pkg.sv
// dm_pkg: shared state/op encodings and default geometry for the data-memory responder.
package dm_pkg;
    localparam int DEF_DEPTH = 1024;
    localparam int DEF_LAT   = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/dm_array.sv
// dm_array: single-port synchronous RAM of 16-bit words with registered read data.
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] index,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[index] <= wdata;
        rdata <= mem[index];
    end
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle data-memory responder that stalls the MEM stage for LAT cycles.
// DM_FAST_RD_EN: reads skip BUSY and complete the cycle after acceptance.
module data_mem_resp
    import dm_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rdy,
    output logic        stall,
    output logic        err
);
    localparam int IW = $clog2(DEPTH);
    state_t state, state_nxt;
    op_t op;
    logic [3:0] cnt;
    logic [IW-1:0] idx, ram_idx;
    logic [15:0] wdata, ram_rdata, rd_hold;
    logic req, fast, hi, oob, err_q, commit;
    assign req = re | we;
    assign hi = |(addr >> IW);
`ifdef DM_FAST_RD_EN
    assign fast = re & ~we;
`else
    assign fast = 1'b0;
`endif
    assign commit = state == BUSY && cnt == 4'd0;
    // The live address drives the RAM while idle so a fast read samples it at acceptance.
    assign ram_idx = state == IDLE ? addr[IW-1:0] : idx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = IDLE;
        rdy = 1'b0;
        stall = 1'b0;
        err = 1'b0;
        rd_data = rd_hold;
        state_nxt = state == IDLE ? (req ? (fast ? DONE : BUSY) : IDLE)
                  : state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
        rdy = state == DONE;
        stall = (state == IDLE && req) || state == BUSY;
        err = state == DONE && err_q;
        rd_data = (state == DONE && op == OP_RD) ? (oob ? 16'h0000 : ram_rdata) : rd_hold;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= 4'd0;
            idx <= '0;
            wdata <= 16'h0000;
            op <= OP_RD;
            oob <= 1'b0;
            err_q <= 1'b0;
            rd_hold <= 16'h0000;
        end else begin
            if (state == IDLE && req) begin
                cnt <= 4'(LAT - 1);
                idx <= addr[IW-1:0];
                wdata <= wrt_data;
                op <= we ? OP_WR : OP_RD;
                oob <= hi;
                err_q <= hi | (re & we);
            end else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == DONE && op == OP_RD) rd_hold <= rd_data;
        end
    dm_array #(.DEPTH(DEPTH)) u_array (
        .clk(clk),
        .we(commit && op == OP_WR && !oob),
        .index(ram_idx),
        .wdata(wdata),
        .rdata(ram_rdata)
    );
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Multi-cycle data-memory responder on the MEM-stage memory interface of the 16-bit pipeline. It accepts one read or write request at a time from the MEM stage over `addr`/`re`/`we`/`wrt_data`. It holds the pipeline with `stall` for a fixed access latency, then returns `rd_data` with a one-cycle `rdy` pulse. It replaces the single-cycle data memory so the pipeline can be exercised against realistic memory latency.

## Interface
- `DEPTH`, 1024: number of 16-bit words; power of two, 2..65536.
- `LAT`, 4: access latency in BUSY cycles; legal range 1..15.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 16: word address.
- `re` in 1: read request.
- `we` in 1: write request.
- `wrt_data` in 16: write data.
- `rd_data` out 16: registered read data; valid while `rdy`=1.
- `rdy` out 1: one-cycle completion pulse for reads and writes.
- `stall` out 1: requester must hold `addr`/`re`/`we`/`wrt_data` stable while 1.
- `err` out 1: one-cycle pulse on out-of-range address or `re`&`we` conflict.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `re`|`we` accepts the request: capture `addr` and `wrt_data`, set the op, load the counter with `LAT-1`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: counter decrements each cycle. At count 0 the captured op is performed on the array and the FSM goes to DONE.
- DONE: `rdy`=1; `rd_data` holds the read result, or is unchanged after a write. The FSM always returns to IDLE; DONE never accepts a request.
- `re`&`we` both 1 at acceptance: the write is performed, the read is ignored, and `err` pulses in DONE.
- Index = `addr[log2(DEPTH)-1:0]`. If any higher `addr` bit is nonzero:
  - Write is dropped.
  - Read returns 16'h0000.
  - `err` pulses in DONE; `rdy` still pulses.
- `stall` is combinational: 1 in IDLE when `re`|`we`, 1 throughout BUSY, 0 in DONE and in IDLE with no request.
- Reset values: state IDLE, counter 0, `rd_data`=16'h0000, `rdy`=0, `stall`=0, `err`=0. Array contents are not reset.
- Reset mid-operation: the request is abandoned. A write is committed only if its commit edge preceded reset assertion.

## Timing
- Request first visible in IDLE in cycle t:
  - `stall`=1 in cycles t..t+LAT.
  - BUSY spans t+1..t+LAT.
  - Array access occurs at the end of t+LAT.
  - DONE in t+LAT+1 with `rdy`=1, `rd_data` valid, `stall`=0.
- Next request is accepted no earlier than t+LAT+2. One idle bubble between back-to-back requests is required behaviour.
- With LAT=1: BUSY lasts one cycle; total occupancy is 3 cycles.
- `rd_data` holds its last value until the next read completes.

## Configuration
- `DM_FAST_RD_EN` defined:
  - Reads bypass BUSY: IDLE→DONE, array read at the end of t, `rdy` and data in t+1, `stall`=1 only in t.
  - Writes keep full LAT timing.
- Undefined: reads and writes both use LAT timing as above.
- `err` and out-of-range rules are identical in both builds.

## Structure
- Shared defines package `dm_pkg`:
  - State encoding (IDLE/BUSY/DONE).
  - Default `LAT`/`DEPTH`.
  - Op encoding (RD/WR).
- One sub-module, `dm_array`: single-port synchronous RAM with clk, we, index, wdata, and registered rdata; no reset.
- The FSM, counter, capture registers and `err` logic live in `data_mem_resp`.

## Test plan
- Reset with `rst_n`=0 then release, no request → `rdy`=0, `stall`=0, `err`=0, `rd_data`=16'h0000.
- LAT=4: write 16'hBEEF to addr 16'h0010 at t → `stall`=1 for t..t+4, `rdy` at t+5. Then read 16'h0010 → `rd_data`=16'hBEEF with `rdy` 5 cycles after request.
- Read addr 16'h0400 (out of range, DEPTH=1024) → `rd_data`=16'h0000, `rdy`=1 and `err`=1 in the same cycle. A prior write to 16'h0400 leaves index 0 unchanged.
- `re`=`we`=1, addr 16'h0003, `wrt_data`=16'h1234 → `err` pulse. A subsequent read of 16'h0003 returns 16'h1234.
- Assert `rst_n`=0 during BUSY of a write to 16'h0020 (initially 16'h5555) → outputs reset immediately. A later read returns 16'h5555.
- `DM_FAST_RD_EN` build: read at t → `stall` only at t, `rdy` and data at t+1. A write still completes at t+LAT+1.
